// File: rtl/adler32_arbiter_if.sv
// ---------------------------------------------------------------------------
// adler32_arbiter_if
// Bundles the requester byte streams, the adler32 engine link and the tagged
// response channel of adler32_arbiter.
//   req_valid/req_last/req_data : requester -> arbiter (byte i at [8i+7:8i])
//   req_ready                   : arbiter -> requester, one-hot while granted
//   eng_*                       : arbiter <-> single adler32 engine
//   rsp_*                       : registered, requester-tagged result
//   busy                        : arbiter not idle
// slave  : the arbiter side
// master : the environment side (requesters, engine, response sink)
// ---------------------------------------------------------------------------
interface adler32_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_last;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;

    logic [7:0]         eng_data;
    logic               eng_data_valid;
    logic               eng_last_data;
    logic               eng_rst_n;
    logic               eng_checksum_valid;
    logic [31:0]        eng_checksum;

    logic               rsp_valid;
    logic [ID_W-1:0]    rsp_id;
    logic [31:0]        rsp_checksum;
    logic               rsp_error;
    logic               busy;

    modport slave (
        input  req_valid, req_last, req_data,
        input  eng_checksum_valid, eng_checksum,
        output req_ready,
        output eng_data, eng_data_valid, eng_last_data, eng_rst_n,
        output rsp_valid, rsp_id, rsp_checksum, rsp_error, busy
    );

    modport master (
        output req_valid, req_last, req_data,
        output eng_checksum_valid, eng_checksum,
        input  req_ready,
        input  eng_data, eng_data_valid, eng_last_data, eng_rst_n,
        input  rsp_valid, rsp_id, rsp_checksum, rsp_error, busy
    );
endinterface

// File: rtl/adler32_arbiter.sv
// ---------------------------------------------------------------------------
// adler32_arbiter
// Shares one adler32 engine among N_REQ byte-stream requesters. A requester
// is granted for a whole message in round-robin order, its bytes are
// forwarded to the engine, and the finished checksum (or a timeout error)
// is returned tagged with the requester index.
//
// Ports:
//   clock  : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : adler32_arbiter_if.slave (requesters, engine link, response)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no grant; pick next requester from rr_ptr when any is valid
// STREAM  | granted requester's bytes flow straight through to the engine
// WAIT    | last byte sent; wait for engine strobe or timeout
// COOL    | one dead cycle while the engine clears; response is visible
// ---------------------------------------------------------------------------
module adler32_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 8
) (
    input  logic             clock,
    input  logic             reset,
    adler32_arbiter_if.slave bus
);
    localparam int              TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COOL   = 2'd3
    } state_t;

    state_t           state_q;
    logic [ID_W-1:0]  grant_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [TMR_W-1:0] timer_q;
    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic [31:0]      rsp_checksum_q;
    logic             rsp_error_q;

    logic [ID_W-1:0]  grant_d;
    logic [ID_W-1:0]  rr_ptr_d;
    logic [ID_W-1:0]  idx;
    logic             found;

    logic [7:0]       sel_byte;
    logic             sel_valid;
    logic             sel_last;

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_d = grant_q;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (!found && bus.req_valid[idx]) begin
                found   = 1'b1;
                grant_d = idx;
            end
        end
        rr_ptr_d = (grant_d == ID_LAST) ? '0 : grant_d + 1'b1;
    end

    always_comb begin
        sel_byte  = bus.req_data[{grant_q, 3'b000} +: 8];
        sel_valid = bus.req_valid[grant_q];
        sel_last  = bus.req_last[grant_q];
    end

    // Stream path is combinational so bytes reach the engine in the cycle
    // they are accepted; last is always qualified by valid.
    always_comb begin
        bus.req_ready      = '0;
        bus.eng_data       = '0;
        bus.eng_data_valid = 1'b0;
        bus.eng_last_data  = 1'b0;
        if (state_q == ST_STREAM) begin
            bus.req_ready[grant_q] = 1'b1;
            bus.eng_data           = sel_byte;
            bus.eng_data_valid     = sel_valid;
            bus.eng_last_data      = sel_valid & sel_last;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            rr_ptr_q       <= '0;
            timer_q        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_checksum_q <= '0;
            rsp_error_q    <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        grant_q  <= grant_d;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    // ready is always high for the grant, so valid == accepted
                    if (sel_valid && sel_last) begin
                        timer_q <= '0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.eng_checksum_valid) begin
                        rsp_valid_q    <= 1'b1;
                        rsp_id_q       <= grant_q;
                        rsp_checksum_q <= bus.eng_checksum;
                        rsp_error_q    <= 1'b0;
                        state_q        <= ST_COOL;
                    end else if (timer_q == TMR_LAST) begin
                        rsp_valid_q    <= 1'b1;
                        rsp_id_q       <= grant_q;
                        rsp_checksum_q <= '0;
                        rsp_error_q    <= 1'b1;
                        state_q        <= ST_COOL;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_COOL: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.eng_rst_n    = ~reset;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_checksum = rsp_checksum_q;
    assign bus.rsp_error    = rsp_error_q;

endmodule

// File: tb/tb_adler32_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adler32_arbiter
// Drives batches of messages (directed and $urandom) into adler32_arbiter,
// models the adler32 engine, and scores every response against a round-robin
// order and a whole-message adler32 computed in the bench.
// ---------------------------------------------------------------------------
module tb_adler32_arbiter;
    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    adler32_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    adler32_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] adler_ref(input logic [7:0] m[$]);
        int a = 1;
        int b = 0;
        foreach (m[i]) begin
            a = (a + int'(m[i])) % 65521;
            b = (b + a) % 65521;
        end
        return {b[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] adler_step(input logic [31:0] st, input logic [7:0] d);
        int a, b;
        a = (int'(st[15:0]) + int'(d)) % 65521;
        b = (int'(st[31:16]) + a) % 65521;
        return {b[15:0], a[15:0]};
    endfunction

    // ---------------- engine model ----------------
    logic [31:0] eng_st;
    logic [31:0] eng_sum;
    logic        eng_v;
    bit          sup = 1'b0;
    logic        stray = 1'b0;

    always @(posedge clock) begin
        if (!bus.eng_rst_n) begin
            eng_st <= 32'h1;
            eng_v  <= 1'b0;
            eng_sum <= 32'h0;
        end else begin
            eng_v <= 1'b0;
            if (bus.eng_data_valid) begin
                if (bus.eng_last_data) begin
                    eng_sum <= adler_step(eng_st, bus.eng_data);
                    eng_v   <= !sup;
                    eng_st  <= 32'h1;
                end else begin
                    eng_st <= adler_step(eng_st, bus.eng_data);
                end
            end
        end
    end

    assign bus.eng_checksum_valid = eng_v | stray;
    assign bus.eng_checksum       = stray ? 32'hDEADBEEF : eng_sum;

    // ---------------- requester / scoreboard state ----------------
    logic [7:0]       msg [N_REQ][$];
    int               pos [N_REQ];
    bit               pend [N_REQ];
    bit               started [N_REQ];
    logic [31:0]      exp_sum [N_REQ];
    int               gap_after [N_REQ];
    bit               gap_used [N_REQ];
    logic [N_REQ-1:0] xfer = '0;
    int               exp_q[$];
    int               model_rr = 0;
    int               cyc = 0;
    int               last_cyc = 0;
    int               busy_cnt = 0;
    int               viol = 0;
    int               gap_pct = 0;
    bit               prev_rsp = 1'b0;
    logic [31:0]      last_id = 0;
    logic [31:0]      last_sum = 0;

    task automatic post(input int i, input logic [7:0] q[$], input logic [31:0] sum);
        msg[i]       = q;
        pos[i]       = 0;
        pend[i]      = 1'b1;
        started[i]   = 1'b0;
        exp_sum[i]   = sum;
        gap_after[i] = -1;
        gap_used[i]  = 1'b0;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N_REQ; i++) begin
            pend[i] = 1'b0;
            bus.req_valid[i] = 1'b0;
        end
        xfer = '0;
        exp_q.delete();
    endtask

    // One clock: commit last cycle's transfers, observe, drive, sample.
    task automatic cycle();
        int g;
        int e;
        @(negedge clock);
        cyc++;
        for (int i = 0; i < N_REQ; i++) begin
            if (xfer[i]) begin
                if (pos[i] == msg[i].size() - 1) last_cyc = cyc - 1;
                started[i] = 1'b1;
                pos[i]++;
                if (pos[i] == msg[i].size()) pend[i] = 1'b0;
            end
        end
        if (bus.busy) busy_cnt++;
        if (bus.rsp_valid) begin
            if (prev_rsp) viol++;
            if (exp_q.size() == 0) begin
                check("rsp_extra", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_id", 32'(bus.rsp_id), e);
                check("rsp_error", 32'(bus.rsp_error), 32'(sup));
                check("rsp_checksum", bus.rsp_checksum, sup ? 32'h0 : exp_sum[e]);
                check("rsp_latency", cyc - last_cyc, sup ? TIMEOUT + 1 : 2);
                last_id  = e;
                last_sum = sup ? 32'h0 : exp_sum[e];
            end
        end
        prev_rsp = bus.rsp_valid;
        for (int i = 0; i < N_REQ; i++) begin
            if (pend[i]) begin
                bus.req_valid[i] = 1'b1;
                if (started[i]) begin
                    if (pos[i] == gap_after[i] && !gap_used[i]) begin
                        bus.req_valid[i] = 1'b0;
                        gap_used[i] = 1'b1;
                    end else if ($urandom_range(0, 99) < gap_pct) begin
                        bus.req_valid[i] = 1'b0;
                    end
                end
                bus.req_data[8*i +: 8] = msg[i][pos[i]];
                bus.req_last[i] = bus.req_valid[i] ? (pos[i] == msg[i].size() - 1)
                                                   : 1'($urandom_range(0, 1));
            end else begin
                bus.req_valid[i] = 1'b0;
                bus.req_data[8*i +: 8] = 8'($urandom_range(0, 255));
                bus.req_last[i] = 1'($urandom_range(0, 1));
            end
        end
        #1;
        xfer = bus.req_valid & bus.req_ready;
        g = -1;
        for (int i = 0; i < N_REQ; i++) if (bus.req_ready[i]) g = i;
        if ($countones(bus.req_ready) > 1) viol++;
        if (exp_q.size() == 0) begin
            if (bus.req_ready != '0) viol++;
        end else if ((bus.req_ready & ~(N_REQ'(1) << exp_q[0])) != '0) begin
            viol++;
        end
        if (bus.eng_data_valid !== (|xfer)) viol++;
        if (bus.eng_last_data !== (|(xfer & bus.req_last))) viol++;
        if (bus.eng_data_valid && g >= 0 && bus.eng_data !== bus.req_data[8*g +: 8]) viol++;
    endtask

    task automatic run_batch(input int gp, input bit sp, output int bcnt);
        int start;
        int lastg;
        lastg = -1;
        for (int k = 0; k < N_REQ; k++) begin
            int i;
            i = (model_rr + k) % N_REQ;
            if (pend[i]) begin
                exp_q.push_back(i);
                lastg = i;
            end
        end
        if (lastg >= 0) model_rr = (lastg + 1) % N_REQ;
        gap_pct  = gp;
        sup      = sp;
        busy_cnt = 0;
        start    = cyc;
        while (exp_q.size() > 0 && cyc - start < 300) cycle();
        check("batch_done", exp_q.size(), 0);
        if (exp_q.size() > 0) clear_reqs();
        bcnt = busy_cnt;
        cycle();
        check("rsp_pulse_width", 32'(bus.rsp_valid), 0);
        check("rsp_id_hold", 32'(bus.rsp_id), last_id);
        check("rsp_sum_hold", bus.rsp_checksum, last_sum);
        sup = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        int bc;
        int n;

        for (int i = 0; i < N_REQ; i++) begin
            pend[i] = 1'b0;
            msg[i].delete();
            pos[i] = 0;
            gap_after[i] = -1;
        end
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;

        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_id", 32'(bus.rsp_id), 0);
        check("rst_rsp_checksum", bus.rsp_checksum, 0);
        check("rst_rsp_error", 32'(bus.rsp_error), 0);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_eng_valid", 32'(bus.eng_data_valid), 0);
        check("rst_eng_last", 32'(bus.eng_last_data), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_eng_rst_n", 32'(bus.eng_rst_n), 0);
        reset = 1'b0;
        #1;
        check("eng_rst_n_release", 32'(bus.eng_rst_n), 1);

        // all four hold "a" from reset: grants 0,1,2,3
        q.delete(); q.push_back(8'h61);
        for (int i = 0; i < N_REQ; i++) post(i, q, 32'h00620062);
        run_batch(0, 1'b0, bc);

        // single-byte message from req0
        post(0, q, 32'h00620062);
        run_batch(0, 1'b0, bc);
        check("single_busy_cycles", bc, 3);

        // "abc" from req2 with a gap after 0x62
        q.delete(); q.push_back(8'h61); q.push_back(8'h62); q.push_back(8'h63);
        post(2, q, 32'h024D0127);
        gap_after[2] = 2;
        run_batch(0, 1'b0, bc);

        // req1 alone, then req1 and req3 together: 3 before 1
        q.delete(); q.push_back(8'h61);
        post(1, q, 32'h00620062);
        run_batch(0, 1'b0, bc);
        post(1, q, 32'h00620062);
        post(3, q, 32'h00620062);
        run_batch(0, 1'b0, bc);

        // engine silent: timeout error, then a normal message
        post(0, q, 32'h00620062);
        run_batch(0, 1'b1, bc);
        q.delete(); q.push_back(8'h61); q.push_back(8'h62); q.push_back(8'h63);
        post(0, q, 32'h024D0127);
        run_batch(20, 1'b0, bc);

        // stray engine strobe while idle is ignored
        @(negedge clock);
        stray = 1'b1;
        @(negedge clock);
        stray = 1'b0;
        check("stray_rsp_valid", 32'(bus.rsp_valid), 0);
        check("stray_busy", 32'(bus.busy), 0);
        check("stray_sum_hold", bus.rsp_checksum, last_sum);

        // reset on the second byte of a 3-byte req1 message
        post(1, q, 32'h024D0127);
        exp_q.push_back(1);
        n = 0;
        while (!(started[1] && pos[1] == 1) && n < 20) begin
            cycle();
            n++;
        end
        check("mid_reached_byte2", 32'(bus.req_valid[1] & bus.req_ready[1]), 1);
        reset = 1'b1;
        #1;
        check("mid_eng_rst_n", 32'(bus.eng_rst_n), 0);
        @(negedge clock);
        reset = 1'b0;
        clear_reqs();
        prev_rsp = 1'b0;
        model_rr = 0;
        #1;
        check("mid_rsp_valid", 32'(bus.rsp_valid), 0);
        check("mid_busy", 32'(bus.busy), 0);
        check("mid_req_ready", 32'(bus.req_ready), 0);
        check("mid_rsp_id", 32'(bus.rsp_id), 0);
        last_id = 0;
        last_sum = 0;
        q.delete(); q.push_back(8'h61);
        post(1, q, 32'h00620062);
        post(3, q, 32'h00620062);
        run_batch(0, 1'b0, bc);

        // randomized batches
        for (int r = 0; r < 12; r++) begin
            int mask;
            mask = $urandom_range(1, (1 << N_REQ) - 1);
            for (int i = 0; i < N_REQ; i++) begin
                if (mask[i]) begin
                    int len;
                    len = $urandom_range(1, 7);
                    q.delete();
                    for (int b = 0; b < len; b++) q.push_back(8'($urandom_range(0, 255)));
                    post(i, q, adler_ref(q));
                end
            end
            run_batch(30, (r % 5) == 3, bc);
        end

        check("protocol_violations", viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
